// File: rtl/seq_mult16_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mult_pkg
//  Purpose : Shared definitions for the seq_mult16 sequential multiplier:
//            FSM state encoding and the fixed operand width / iteration count.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MULT_W    = 16;
  localparam int MULT_ITER = 16;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/seq_mult16_if.sv
`default_nettype none
// ============================================================================
//  Module  : seq_mult16_if
//  Purpose : Start/done handshake and operand/result bus of seq_mult16.
//  Ports   : start, a_in, b_in  (master -> slave)
//            busy, done, product (slave -> master)
//            master = control logic, slave = multiplier
//  Rev     : 1.0  initial release
// ============================================================================
interface seq_mult16_if;
  import mult_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a_in;
  logic [MULT_W-1:0]     b_in;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   product;

  modport master (
    output start, a_in, b_in,
    input  busy, done, product
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, product
  );

endinterface : seq_mult16_if
`default_nettype wire

// File: rtl/seq_mult16_adder.sv
`default_nettype none
// ============================================================================
//  Module  : adder
//  Purpose : Combinational ripple-carry adder used by seq_mult16 for one
//            partial-product accumulation per cycle.
//  Ports   : a, b   [WIDTH-1:0] operands
//            c_in   carry in
//            sum    [WIDTH-1:0] result
//            c_out  carry out of the top bit
//  Rev     : 1.0  initial release
// ============================================================================
module adder #(
  parameter int WIDTH = 16
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic             c_in,
  output logic      [WIDTH-1:0] sum,
  output logic                  c_out
);

  // Running carry of the ripple chain, walked LSB to MSB.
  logic carry;

  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule : adder
`default_nettype wire

// File: rtl/seq_mult16.sv
`default_nettype none
// ============================================================================
//  Module  : seq_mult16
//  Purpose : 16x16 unsigned shift-add multiplier, one partial product per
//            cycle through a single ripple adder; 32-bit product after 16
//            iterations, start/done handshake.
//  Ports   : clk    system clock, rising edge
//            rst_n  asynchronous active-low reset
//            bus    seq_mult16_if.slave (start, a_in, b_in, busy, done,
//                   product)
//  Option  : ZERO_SKIP_EN - when defined, a zero operand at accept jumps
//            straight to DONE with product 0 instead of running 16 CALC
//            cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module seq_mult16
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  seq_mult16_if.slave  bus
);

  if (WIDTH != MULT_W) begin : g_bad_width
    $error("seq_mult16: WIDTH must be 16 to match adder");
  end

  if ((2 ** CNT_W) <= (MULT_ITER - 1)) begin : g_bad_cnt_w
    $error("seq_mult16: CNT_W too narrow for the iteration count");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_ITER - 1);

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  // Upper half holds the running partial sum, lower half the not-yet-used
  // multiplier bits. The conceptual bit 32 is always zero after a shift, so
  // it is not stored.
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 zero_op;

  assign add_b = acc[0] ? mcand : '0;

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (acc[2*WIDTH-1:WIDTH]),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // {carry, sum} shifts right together with the low half; the carry lands
  // in the top bit so nothing is ever lost.
  assign acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};

`ifdef ZERO_SKIP_EN
  assign zero_op = (bus.a_in == '0) || (bus.b_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a_in;
            acc   <= {{WIDTH{1'b0}}, bus.b_in};
            cnt   <= '0;
            if (zero_op) begin
              product_q <= '0;
              state     <= DONE;
            end else begin
              state     <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product_q <= acc_next;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the state register only: no path from start to busy/done.
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule : seq_mult16
`default_nettype wire

// File: tb/tb_seq_mult16.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_mult16
//  Purpose : Self-checking bench for seq_mult16: directed vector table,
//            start-while-busy, reset mid-operation and randomized
//            back-to-back operation against an arithmetic reference.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_seq_mult16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_mult16_if bus ();

  seq_mult16 #(
    .WIDTH (16),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Edges after the accept edge until done is visible.
  function automatic int exp_latency(input logic [15:0] a, input logic [15:0] b);
    int lat;
    lat = 16;
`ifdef ZERO_SKIP_EN
    if (a == 16'h0 || b == 16'h0) lat = 0;
`endif
    return lat;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = 16'($urandom);
    bus.b_in  = 16'($urandom);
    check({name, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i <= 40 && !seen; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_latency(a, b)));
    check({name, "_product"}, bus.product, exp);
    @(posedge clk);
    #1;
    check({name, "_done_cleared"}, 32'(bus.done), 32'd0);
    check({name, "_idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] model;
  bit          seen;
  int          ndone;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = 16'h0;
    bus.b_in  = 16'h0;

    vecs[0] = '{16'd3,     16'd5,     32'h0000_000F, "basic_3x5"};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE_0001, "max_x_max"};
    vecs[2] = '{16'h8000,  16'h0002,  32'h0001_0000, "carry_8000x2"};
    vecs[3] = '{16'h0000,  16'h1234,  32'h0000_0000, "zero_a"};
    vecs[4] = '{16'h1234,  16'h0000,  32'h0000_0000, "zero_b"};
    vecs[5] = '{16'h0001,  16'h0001,  32'h0000_0001, "one_x_one"};
    vecs[6] = '{16'hFFFF,  16'h0001,  32'h0000_FFFF, "max_x_one"};
    vecs[7] = '{16'h1234,  16'h5678,  32'h0626_0060, "mixed"};
    vecs[8] = '{16'hFFFF,  16'h8000,  32'h7FFF_8000, "max_x_msb"};
    vecs[9] = '{16'd100,   16'd200,   32'd20000,     "dec_100x200"};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",    32'(bus.busy), 32'd0);
    check("reset_done",    32'(bus.done), 32'd0);
    check("reset_product", bus.product,   32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // start pulses while busy (mid-CALC and during DONE) are ignored
    @(negedge clk);
    bus.a_in  = 16'd7;
    bus.b_in  = 16'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    seen  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.a_in  = 16'd1;
        bus.b_in  = 16'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (!seen) begin
          seen = 1'b1;
          check("busy_start_product", bus.product, 32'h0000_003F);
          bus.start = 1'b1;
          bus.a_in  = 16'd1;
          bus.b_in  = 16'd1;
        end
      end
    end
    check("busy_start_single_done", 32'(ndone), 32'd1);
    check("busy_start_idle",        32'(bus.busy), 32'd0);
    check("busy_start_product_kept", bus.product, 32'h0000_003F);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.a_in  = 16'd100;
    bus.b_in  = 16'd200;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy",    32'(bus.busy), 32'd0);
    check("midreset_done",    32'(bus.done), 32'd0);
    check("midreset_product", bus.product,   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd100, 16'd200, 32'd20000, "after_reset");

    // Back-to-back, start held high, operands change every cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 16'($urandom_range(1, 65535));
    bus.b_in  = 16'($urandom_range(1, 65535));
    for (int c = 0; c < 1000 * 18; c++) begin
      @(posedge clk);
      if (c % 18 == 0) exp_q.push_back(32'(bus.a_in) * 32'(bus.b_in));
      @(negedge clk);
      check("b2b_done_timing", 32'(bus.done), 32'((c % 18) == 16));
      if ((c % 18) == 16 && exp_q.size() > 0) begin
        model = exp_q.pop_front();
        check("b2b_product", bus.product, model);
      end
      bus.a_in = 16'($urandom_range(1, 65535));
      bus.b_in = 16'($urandom_range(1, 65535));
    end
    bus.start = 1'b0;
    check("b2b_all_consumed", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_mult16
`default_nettype wire

// File: doc/seq_mult16.md
Name: seq_mult16

Overview:
- Sequential 16x16 unsigned shift-add multiplier.
- Sits directly upstream of the team's 16-bit ripple adder `adder`. It feeds `adder` one partial-product operand pair per cycle and consumes its sum and carry-out.
- Produces a 32-bit product after 16 iterations.
- Start/done handshake to the control logic above it.

Parameters:
- WIDTH, 16, operand width; fixed at 16 to match `adder`. Any other value is a elaboration error.
- CNT_W, 5, iteration counter width; must hold the value WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  16  multiplicand; captured on accept.
- b_in  input  16  multiplier; captured on accept.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when product is valid.
- product  output  32  last completed result; holds until the next completion.

Behaviour:
- Reset (asynchronous assert on rst_n low, synchronous release):
  - state=IDLE.
  - mcand=0, acc[32:0]=0, cnt=0.
  - product=0, busy=0, done=0.
- States:
  - IDLE:
    - start=1 -> accept: mcand<=a_in, acc<={17'b0,b_in}, cnt<=0; next state CALC.
    - start=0 -> stay in IDLE.
  - CALC, one iteration per cycle:
    - `adder` inputs: a=acc[31:16], b = acc[0] ? mcand : 16'h0.
    - acc <= {1'b0, c_out, sum, acc[15:1]}, i.e. the 17-bit {carry,sum} is shifted right one place together with the low half.
    - cnt <= cnt+1.
    - When cnt==15 on this edge: product<=next acc[31:0], next state DONE.
  - DONE:
    - done=1, busy=1 for exactly one cycle.
    - Next state IDLE unconditionally.
- Latency:
  - Accept edge E.
  - Iterations at edges E+1..E+16.
  - done high in the cycle after edge E+16.
  - Next start can be accepted at edge E+18 at the earliest.
- Handshake:
  - start is ignored while busy=1, including the DONE cycle.
  - No queuing.
  - a_in/b_in may change freely after the accept edge.
- Width/arithmetic:
  - Carry out of `adder` is never dropped; it becomes acc[31] after the shift.
  - The result is the exact unsigned 32-bit product; overflow is impossible.
- Outputs:
  - done and busy are decoded from the state register only (glitch-free, no combinational path from start).
  - product is registered and changes only on the DONE-entry edge.
- Reset mid-operation: aborts immediately. product returns to 0; no done pulse.
- start held high continuously: one accept per IDLE visit, giving back-to-back operations every 18 cycles.

Optional Feature:
- Macro ZERO_SKIP_EN.
- Defined:
  - At accept, if a_in==0 or b_in==0, go IDLE->DONE directly (skip CALC) with product<=0.
  - done is high in the cycle after the accept edge.
  - Non-zero operands behave exactly as the base design.
- Undefined:
  - Every operation runs the full 16 CALC cycles, zero operands included.
  - The result is still 0.

Decomposition:
- Shared package (mult_pkg):
  - state encoding typedef: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - constant MULT_W=16.
  - constant MULT_ITER=16.
- Sub-module: exactly one instance of the existing `adder` (16-bit ripple-carry, carry-in tied 0).
  - All sequencing, the accumulator and the counter live in seq_mult16.
  - No second adder.

Test Plan:
- Basic product: a=3, b=5, start pulse -> busy=1 next cycle; done=1 exactly 17 cycles after the accept edge; product=32'h0000_000F; busy=0 after done.
- Carry path: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE_0001. Also a=16'h8000, b=16'h0002 -> 32'h0001_0000.
- start while busy: accept a=7, b=9, then pulse start with a=1, b=1 at cycles 5 and during DONE -> single done, product=32'h0000_003F, no second operation.
- Reset mid-op: accept a=100, b=200, drop rst_n at cycle 8 -> immediately busy=0, done=0, product=0. After release, a=100, b=200 -> product=32'd20000.
- Zero operand: a=0, b=16'h1234. With ZERO_SKIP_EN, done is 1 cycle after accept. Without it, done comes after 16 CALC cycles. Both give product=0.
- Back-to-back with start held high and random operands (1000 pairs) -> every done matches a*b; accept spacing is exactly 18 cycles.
